// File: rtl/i2c_txn_arbiter_if.sv
// Command channel between the transaction arbiter (master) and a byte-level I2C read engine (slave).
interface i2c_txn_arbiter_if;
  logic        valid;
  logic        ready;
  logic [6:0]  addr;
  logic [7:0]  sub;
  logic        len;
  logic        abort;
  logic        done;
  logic [15:0] data;
  logic        nack;

  modport master (output valid, addr, sub, len, abort, input ready, done, data, nack);
  modport slave  (input valid, addr, sub, len, abort, output ready, done, data, nack);
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one I2C read engine: grant to m.valid is 1 cycle, m.valid waits on m.ready,
// a response timeout aborts a stuck engine, and a fixed idle gap follows every completion.
module i2c_txn_arbiter #(
  parameter int NREQ       = 2,
  parameter int TIMEOUT    = 65535,
  parameter int GAP_CYCLES = 100
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [NREQ-1:0]     req_i,
  input  logic [7*NREQ-1:0]   req_addr_i,
  input  logic [8*NREQ-1:0]   req_sub_i,
  input  logic [NREQ-1:0]     req_len_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [NREQ-1:0]     done_o,
  output logic [15:0]         rdata_o,
  output logic                err_o,
  output logic                busy_o,
  i2c_txn_arbiter_if.master   m
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      sub_q, sub_d;
  logic            len_q, len_d;
  logic [15:0]     timer_q, timer_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            found;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   idx;
  logic            expire;

  // First requesting index at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Last WAIT cycle with no response; a same-cycle m.done suppresses the abort.
  assign expire = (state_q == S_WAIT) && (timer_q == 16'd1) && !m.done;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    sub_d   = sub_q;
    len_d   = len_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          addr_d     = req_addr_i[7*int'(sel) +: 7];
          sub_d      = req_sub_i[8*int'(sel) +: 8];
          len_d      = req_len_i[sel];
          ptr_d      = (int'(sel) == NREQ-1) ? '0 : sel + PW'(1);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m.ready) begin
          timer_d = 16'(TIMEOUT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q - 16'd1;
        if (m.done) begin
          err_d   = m.nack;
          rdata_d = len_q ? m.data : {8'h00, m.data[15:8]};
          state_d = S_DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          rdata_d = 16'hFFFF;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        gap_d   = 16'(GAP_CYCLES);
        state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q <= 16'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      sub_q   <= '0;
      len_q   <= 1'b0;
      timer_q <= '0;
      gap_q   <= '0;
      rdata_q <= 16'hFFFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      sub_q   <= sub_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = (state_q == S_DONE) ? gnt_q : '0;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != S_IDLE);
  assign m.valid = (state_q == S_ISSUE);
  assign m.addr  = addr_q;
  assign m.sub   = sub_q;
  assign m.len   = len_q;
  assign m.abort = expire;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: expected completions are queued as requests are posted
// and compared when done pulses; timing of gap and abort is measured in clock cycles.
module tb_i2c_txn_arbiter;
  localparam int NREQ = 2;
  localparam int TOUT = 20;
  localparam int GAP  = 100;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_len = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [8*NREQ-1:0] req_sub = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [15:0]       rdata;
  logic              err, busy;

  i2c_txn_arbiter_if m ();

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(TOUT), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .reset_ni(reset_n), .req_i(req), .req_addr_i(req_addr), .req_sub_i(req_sub),
    .req_len_i(req_len), .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .err_o(err), .busy_o(busy),
    .m(m)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int acc_cyc = 0, abort_cyc = 0, abort_cnt = 0, done_cnt = 0, a0 = 0, d0 = 0;

  typedef struct packed {logic [1:0] gnt; logic [15:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  exp_t e_mon;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completion scoreboard and event timestamps, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      if (m.valid && m.ready) acc_cyc = cyc;
      if (m.abort) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
      if (done != '0) begin
        done_cnt++;
        if (sb.size() == 0) check("done_unexpected", 32'(done), 32'd0);
        else begin
          e_mon = sb.pop_front();
          check("done_vec", 32'(done), 32'(e_mon.gnt));
          check("gnt_at_done", 32'(gnt), 32'(e_mon.gnt));
          check("rdata", 32'(rdata), 32'(e_mon.rdata));
          check("err", 32'(err), 32'(e_mon.err));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] s, input logic l);
    req_addr[7*i +: 7] = a;
    req_sub[8*i +: 8]  = s;
    req_len[i]         = l;
    req[i]             = 1'b1;
  endtask

  task automatic expect_txn(input logic [1:0] g, input logic [15:0] r, input logic e);
    sb.push_back('{gnt: g, rdata: r, err: e});
  endtask

  // Engine model: accept after rdy_dly cycles; done_dly = WAIT cycle (1-based) carrying m.done, 0 = never.
  task automatic serve(input logic [1:0] eg, input logic [6:0] ea, input logic [7:0] es, input logic el,
                       input int rdy_dly, input int done_dly, input logic [15:0] data, input logic nack);
    int n = 0;
    while (!m.valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("valid_seen", 32'(m.valid), 32'd1);
    if (m.valid) begin
      check("gnt", 32'(gnt), 32'(eg));
      check("m_addr", 32'(m.addr), 32'(ea));
      check("m_sub", 32'(m.sub), 32'(es));
      check("m_len", 32'(m.len), 32'(el));
      repeat (rdy_dly) begin @(posedge clk); #1; end
      check("valid_held", 32'(m.valid), 32'd1);
      m.ready = 1'b1;
      @(posedge clk); #1;
      m.ready = 1'b0;
      check("valid_drop", 32'(m.valid), 32'd0);
      if (done_dly > 0) begin
        repeat (done_dly - 1) begin @(posedge clk); #1; end
        m.done = 1'b1; m.data = data; m.nack = nack;
        @(posedge clk); #1;
        m.done = 1'b0; m.nack = 1'b0; m.data = 16'h0000;
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 500);
    check("done_seen", 32'(done != '0), 32'd1);
  endtask

  task automatic count_gap(input int exp);
    int n = 0;
    @(negedge clk);
    check("gnt_clear", 32'(gnt), 32'd0);
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("gap_len", 32'(n), 32'(exp));
  endtask

  task automatic check_reset_vals();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(rdata), 32'hFFFF);
    check("rst_valid", 32'(m.valid), 32'd0);
    check("rst_abort", 32'(m.abort), 32'd0);
    check("rst_addr", 32'(m.addr), 32'd0);
    check("rst_sub", 32'(m.sub), 32'd0);
    check("rst_len", 32'(m.len), 32'd0);
  endtask

  initial begin
    m.ready = 1'b0; m.done = 1'b0; m.data = 16'h0000; m.nack = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Two-byte read from requester 0, accepted after 3 cycles.
    set_req(0, 7'h4B, 8'h0B, 1'b1);
    expect_txn(2'b01, 16'h1A80, 1'b0);
    serve(2'b01, 7'h4B, 8'h0B, 1'b1, 3, 4, 16'h1A80, 1'b0);
    wait_done();
    req = '0;
    count_gap(GAP);

    // One-byte read: only the first received byte is returned.
    @(posedge clk); #1;
    set_req(1, 7'h48, 8'h00, 1'b0);
    expect_txn(2'b10, 16'h005C, 1'b0);
    serve(2'b10, 7'h48, 8'h00, 1'b0, 0, 2, 16'h5C37, 1'b0);
    wait_done();
    req = '0;
    count_gap(GAP);

    // Both requesting continuously: grants alternate.
    @(posedge clk); #1;
    set_req(0, 7'h4B, 8'h0B, 1'b1);
    set_req(1, 7'h48, 8'h01, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        expect_txn(2'b01, 16'h1100 + 16'(k), 1'b0);
        serve(2'b01, 7'h4B, 8'h0B, 1'b1, 1, 3, 16'h1100 + 16'(k), 1'b0);
      end else begin
        expect_txn(2'b10, 16'h1100 + 16'(k), 1'b0);
        serve(2'b10, 7'h48, 8'h01, 1'b1, 1, 3, 16'h1100 + 16'(k), 1'b0);
      end
      wait_done();
      if (k == 3) req = '0;
      count_gap(GAP);
    end

    // NACK: error flagged, data passed through, no abort.
    @(posedge clk); #1;
    set_req(0, 7'h4B, 8'h0B, 1'b1);
    expect_txn(2'b01, 16'h1234, 1'b1);
    a0 = abort_cnt;
    serve(2'b01, 7'h4B, 8'h0B, 1'b1, 0, 2, 16'h1234, 1'b1);
    wait_done();
    check("nack_no_abort", 32'(abort_cnt), 32'(a0));
    req = '0;
    count_gap(GAP);

    // Timeout: accept edge closes cycle N, abort is high in cycle N+20.
    @(posedge clk); #1;
    set_req(1, 7'h48, 8'h01, 1'b1);
    expect_txn(2'b10, 16'hFFFF, 1'b1);
    a0 = abort_cnt;
    serve(2'b10, 7'h48, 8'h01, 1'b1, 0, 0, 16'h0000, 1'b0);
    wait_done();
    check("abort_once", 32'(abort_cnt), 32'(a0 + 1));
    check("abort_latency", 32'(abort_cyc - acc_cyc), 32'(TOUT));
    req = '0;
    count_gap(GAP);

    // m.done in the final timer cycle wins over expiry.
    @(posedge clk); #1;
    set_req(1, 7'h48, 8'h01, 1'b1);
    expect_txn(2'b10, 16'hBEEF, 1'b1);
    a0 = abort_cnt;
    serve(2'b10, 7'h48, 8'h01, 1'b1, 0, TOUT, 16'hBEEF, 1'b1);
    wait_done();
    check("race_no_abort", 32'(abort_cnt), 32'(a0));
    req = '0;
    count_gap(GAP);

    // Reset while waiting for the engine: no done, no abort, outputs back to reset values.
    @(posedge clk); #1;
    set_req(0, 7'h4B, 8'h0B, 1'b1);
    a0 = abort_cnt;
    d0 = done_cnt;
    serve(2'b01, 7'h4B, 8'h0B, 1'b1, 0, 0, 16'h0000, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("busy_in_wait", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    req = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_no_done", 32'(done_cnt), 32'(d0));
    check("rst_no_abort", 32'(abort_cnt), 32'(a0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Pointer restarts at requester 0 after reset.
    set_req(0, 7'h4B, 8'h0B, 1'b1);
    set_req(1, 7'h48, 8'h01, 1'b1);
    expect_txn(2'b01, 16'h0F0F, 1'b0);
    serve(2'b01, 7'h4B, 8'h0B, 1'b1, 0, 1, 16'h0F0F, 1'b0);
    wait_done();
    req = '0;
    count_gap(GAP);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one byte-level I2C read master between NREQ requesters, e.g. the temperature poller and the configuration block.
- Each requester asks for a register read: device address, sub-address, then 1 or 2 data bytes via repeated start.
- The arbiter grants round-robin, issues one command to the master, and enforces a response timeout.
- It returns read data and error status to the granted requester, then holds a bus-free gap before the next grant.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 65535, clk cycles allowed from command accept to m_done before abort (≥1, fits 16 bits).
- GAP_CYCLES, 100, idle clk cycles between transactions (0 = none, fits 16 bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- req_addr  in  7*NREQ  packed 7-bit device addresses; requester i uses bits [7i+6:7i].
- req_sub  in  8*NREQ  packed sub-addresses; requester i uses bits [8i+7:8i].
- req_len  in  NREQ  per requester: 0 = 1 byte, 1 = 2 bytes.
- gnt  out  NREQ  one-hot grant, held for the whole transaction.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- rdata  out  16  read result, valid when any done bit is high.
- err  out  1  NACK or timeout flag, valid with done.
- busy  out  1  high in any state other than IDLE.
- m_valid  out  1  command valid to the master.
- m_ready  in  1  master accepts the command.
- m_addr  out  7  latched device address.
- m_sub  out  8  latched sub-address.
- m_len  out  1  latched length.
- m_abort  out  1  one-cycle pulse: master must release the bus and go idle.
- m_done  in  1  one-cycle pulse: transaction finished.
- m_data  in  16  bytes from the master; first byte received in [15:8].
- m_nack  in  1  NACK seen; valid with m_done.

Behaviour:
- Reset values:
  - gnt = 0, done = 0, err = 0, busy = 0, m_valid = 0, m_abort = 0.
  - m_addr = 0, m_sub = 0, m_len = 0.
  - rdata = 16'hFFFF.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
- Reset mid-transaction returns immediately to IDLE. No done pulse is issued and no abort pulse is issued.
- State IDLE:
  - If any req bit is high, select the first requester at or above the pointer, wrapping modulo NREQ.
  - Latch its addr, sub and len onto m_*, set its gnt bit, and set pointer = selected + 1 (mod NREQ).
  - Go to ISSUE. Grant decision to m_valid high is 1 cycle.
- State ISSUE:
  - m_valid = 1; m_* are stable.
  - When m_valid and m_ready are both high, load the timer with TIMEOUT and go to WAIT. m_valid drops the next cycle.
  - No timeout applies while waiting for m_ready.
- State WAIT: the timer decrements each cycle.
  - On m_done: err = m_nack. rdata = m_data if m_len = 1; otherwise rdata = {8'h00, m_data[15:8]}. Go to DONE.
  - If the timer reaches 0 without m_done: m_abort pulses for 1 cycle, err = 1, rdata = 16'hFFFF, go to DONE.
  - If m_done and timer expiry occur in the same cycle, m_done wins and no abort is issued.
- State DONE:
  - done[granted] = 1 for exactly 1 cycle.
  - gnt clears on the same edge that done falls.
  - Load the gap counter; go to GAP, or go to IDLE if GAP_CYCLES = 0.
- State GAP:
  - Count down GAP_CYCLES cycles, then go to IDLE. req is ignored during GAP.
- rdata and err hold their values until the next completion.
- If a requester drops req while granted, the transaction still completes and done is still pulsed.
- A requester must not present a new request until done has been seen.
- req bits that change while busy only affect the next arbitration.
- gnt is never multi-hot. done is never high outside the DONE state.

Test Plan:
- Single 2-byte read: req = 01, addr 0x4B, sub 0x0B, len 1; master accepts after 3 cycles and returns m_data 0x1A80 with nack 0 → gnt = 01, done[0] pulses once, rdata = 0x1A80, err = 0, then busy stays high for 100 gap cycles.
- 1-byte read: len 0, m_data 0x5Cxx → rdata = 0x005C.
- Round-robin: req = 11 held continuously → grants alternate 01, 10, 01, 10 across four transactions, each separated by ≥ GAP_CYCLES idle cycles.
- NACK: m_done with m_nack = 1 → err = 1 with done, no m_abort pulse.
- Timeout (TIMEOUT = 20): m_done never arrives → m_abort pulses exactly 20 cycles after accept, done pulses with err = 1 and rdata = 0xFFFF.
- Same-cycle m_done and expiry → no abort, err = m_nack. Then assert reset in WAIT → all outputs return to reset values with no done pulse.
